// File: rtl/lzx_irq_pkg.sv
// Shared types and sizes for the lzx_irq_ctrl interrupt controller.
package lzx_irq_pkg;
  localparam int NUM_CH = 8;
  localparam int VEC_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;
endpackage

// File: rtl/lzx_74HC148.sv
// Behavioural 74HC148 8-to-3 priority encoder: active-low inputs and outputs, input 7 highest.
module lzx_74HC148 (
  input  logic [7:0] din,
  input  logic       EI_n,
  output logic [2:0] dout_n,
  output logic       GS_n,
  output logic       EO_n
);
  always_comb begin
    dout_n = 3'b111;
    GS_n   = 1'b1;
    EO_n   = 1'b1;
    if (!EI_n) begin
      EO_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!din[i]) begin
          dout_n = ~3'(i);
          GS_n   = 1'b0;
          EO_n   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/lzx_irq_ctrl.sv
// Eight-channel interrupt controller: latches requests, masks, arbitrates via lzx_74HC148, irq/ack/eoi handshake.
// Define LZX_IRQ_ROTATE_EN for rotating priority; default build uses fixed priority (ch7 highest).
module lzx_irq_ctrl
  import lzx_irq_pkg::*;
#(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_CH-1:0] req_n,
  input  logic [NUM_CH-1:0] mask,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  output logic             busy,
  output logic [NUM_CH-1:0] pend
);
  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_req_prev, r_pend;
  logic [NUM_CH-1:0]   w_elig, w_rot, w_set, w_clr;
  logic [VEC_W-1:0]    r_vec, w_enc, w_win;
  logic                r_vec_valid;
  logic [2:0]          w_dout_n;
  logic                w_gs_n, w_eo_n, w_any, w_take;

  assign w_elig = r_pend & ~mask;
  assign w_set  = ~req_n & ~r_req_prev;

`ifdef LZX_IRQ_ROTATE_EN
  logic [VEC_W-1:0] r_ptr, w_shift;

  // Rotate so channel r_ptr lands on encoder input 7; undo the offset on the way out.
  assign w_shift = r_ptr + 3'd1;

  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NUM_CH; j++)
      w_rot[j] = w_elig[VEC_W'(VEC_W'(j) + w_shift)];
  end

  assign w_win = w_enc + w_shift;

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= 3'd7;
    else if (r_state == SERV && eoi)
      r_ptr <= r_vec - 3'd1;
  end
`else
  assign w_rot = w_elig;
  assign w_win = w_enc;
`endif

  lzx_74HC148 u_enc (
    .din    (~w_rot),
    .EI_n   (1'b0),
    .dout_n (w_dout_n),
    .GS_n   (w_gs_n),
    .EO_n   (w_eo_n)
  );

  assign w_enc  = ~w_dout_n;
  // GS_n low already implies EO_n high; both are folded in so no encoder output dangles.
  assign w_any  = !w_gs_n && w_eo_n;
  assign w_take = (r_state == REQ) && ack && w_any;
  assign w_clr  = w_take ? (NUM_CH'(1) << w_win) : '0;

  always_comb begin
    w_state_nxt = r_state;
    irq         = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = REQ;
      REQ: begin
        irq = 1'b1;
        if (!w_any)   w_state_nxt = IDLE;
        else if (ack) w_state_nxt = SERV;
      end
      SERV: begin
        busy = 1'b1;
        if (eoi) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_prev  <= '0;
      r_pend      <= '0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_prev <= ~req_n;
      // A fresh edge on the granted channel re-arms it: set wins over clear.
      if (LEVEL_MODE) r_pend <= ~req_n;
      else            r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_take) begin
        r_vec       <= w_win;
        r_vec_valid <= 1'b1;
      end else if (r_state == SERV && eoi) begin
        r_vec_valid <= 1'b0;
      end
    end
  end

  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;
  assign pend      = r_pend;
endmodule

// File: doc/lzx_irq_ctrl.md
# lzx_irq_ctrl

Eight-channel interrupt controller built around the lzx_74HC148 priority encoder. It latches active-low request lines and applies a mask, then uses the encoder to pick the winning channel. It drives a single irq/ack/eoi handshake toward the consumer and allows exactly one channel in service at a time. It is the block that sequences and shares the encoder among eight requesters.

## Interface
- LEVEL_MODE, default 0: 0 = falling edges on req_n are latched into sticky pending bits; 1 = pending mirrors the live request level and is not sticky.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_n  in  8  active-low requests; bit 7 is the highest fixed priority, matching lzx_74HC148
- mask  in  8  1 = channel masked: not eligible, but its pending bit is still recorded
- ack  in  1  consumer accepts the pending irq
- eoi  in  1  end of service for the current vec
- irq  out  1  interrupt request to the consumer
- vec  out  3  channel number in service
- vec_valid  out  1  vec is meaningful; high throughout SERV
- busy  out  1  a channel is in service
- pend  out  8  pending register, active-high

## Operation
- Request history req_prev holds the registered ~req_n.
- Edge mode: pend[i] is set when ~req_n[i] is high and req_prev[i] is low.
- Level mode: pend[i] is assigned ~req_n[i] every cycle.
- Eligible set: elig = pend & ~mask.
- FSM states are IDLE, REQ and SERV.
- IDLE: if elig != 0, go to REQ.
- REQ:
  - irq = 1.
  - If elig == 0 (masked or withdrawn), return to IDLE.
  - On ack: vec <= winner of elig in that cycle, vec_valid <= 1, clear pend[winner] (edge mode only), go to SERV.
- SERV: irq = 0, busy = 1, vec held. On eoi: vec_valid <= 0, go to IDLE.
- Ignored events:
  - ack outside REQ.
  - eoi outside SERV.
  - ack and eoi in the same REQ cycle: ack is taken, eoi is ignored.
- Set beats clear: a new edge on the channel being cleared in the ack cycle leaves its pend bit at 1.
- Reset values:
  - irq, vec, vec_valid, busy and pend are all 0; state is IDLE.
  - req_prev is 0 (inactive). A line already held low when reset releases is therefore seen as an edge in the first cycle.
- Reset mid-service drops the service state without an eoi.

## Timing
- req_n falls before edge n, pend is set at edge n, and irq is high after edge n+1 (2-cycle request latency).
- ack sampled at edge m gives vec, vec_valid and busy after edge m; irq is low after edge m.
- eoi sampled at edge k returns the FSM to IDLE after k. If more eligible requests remain, irq rises again after k+1.
- Winner selection is combinational from registered pend and the registered rotation pointer. It is sampled only on the ack edge.

## Configuration
- LZX_IRQ_ROTATE_EN defined: rotating priority.
  - 3-bit pointer ptr, reset 7, names the highest-priority channel; priority descends modulo 8 from ptr.
  - On eoi, ptr <= vec - 1 mod 8, so the just-serviced channel becomes lowest priority.
- Not defined: fixed priority with 7 highest; no pointer register exists.

## Structure
- Package lzx_irq_pkg holds:
  - the state enum (IDLE, REQ, SERV);
  - constant NUM_CH = 8;
  - constant VEC_W = 3.
- One sub-module: lzx_74HC148, instantiated unmodified.
  - din = ~rotated elig, EI_n = 0.
  - winner = ~dout_n, plus ptr - 7 mod 8 in rotating mode.
  - GS_n = 1 means no winner.

## Test plan
- Reset: rst high for 2 cycles with req_n = 8'hFF. Then irq = 0, vec = 0, vec_valid = 0, busy = 0, pend = 8'h00, and they stay there with no requests.
- Single request: req_n = 8'hFE. irq rises 2 cycles later; ack gives vec = 0, vec_valid = 1, pend = 8'h00; eoi gives busy = 0 and vec_valid = 0 the next cycle.
- Fixed priority: req_n = 8'h55 pulsed once, then repeated ack/eoi cycles. vec order is 7, 5, 3, 1, ending with pend = 8'h00 and irq = 0.
- Mask: mask = 8'h80 with ch7 and ch0 pulsed. The first grant is vec = 0 and pend[7] stays 1. Clearing the mask gives the next grant vec = 7.
- Rotation, with LZX_IRQ_ROTATE_EN: service ch7, then pend ch7 and ch6 together. Next vec = 6. Without the macro, next vec = 7.
- Withdrawal, with LEVEL_MODE = 1: ch3 goes low, irq rises, then ch3 goes high before ack. irq drops, the FSM returns to IDLE, and a following ack is ignored (vec_valid stays 0).
